compare_unit: RTL

- Parametrised, multi-cycle magnitude/equality comparator. Successor to the single-cycle combinational equality block.
- Compares two BUS_SIZE-bit operands CHUNK_SIZE bits per cycle, starting at the MSB chunk and terminating early on the first differing chunk.
- Supports six compare modes (signed and unsigned) behind valid/ready handshakes.
- Sits in the math unit between operand latch and branch/flag logic.

---
 rtl/compare_unit_pkg.sv | 47 ++++
 rtl/compare_unit_if.sv | 30 +++
 rtl/compare_chunk.sv | 15 +
 rtl/compare_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/compare_unit_pkg.sv
// Shared definitions for the multi-cycle compare unit.
// Holds op codes, FSM states and small helpers for chunk count and result selection.
package cmp_pkg;

    // Compare op codes; 6 and 7 are illegal.
    localparam logic [2:0] OP_EQ  = 3'd0;
    localparam logic [2:0] OP_NE  = 3'd1;
    localparam logic [2:0] OP_LTU = 3'd2;
    localparam logic [2:0] OP_GEU = 3'd3;
    localparam logic [2:0] OP_LTS = 3'd4;
    localparam logic [2:0] OP_GES = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nchunk(input int bus_size, input int chunk_size);
        return bus_size / chunk_size;
    endfunction

    function automatic logic op_signed(input logic [2:0] op);
        return (op == OP_LTS) || (op == OP_GES);
    endfunction

    function automatic logic op_illegal(input logic [2:0] op);
        return op > OP_GES;
    endfunction

    // Maps the final eq/lt flags onto the single result bit for an op.
    function automatic logic op_result(input logic [2:0] op,
                                       input logic       eq,
                                       input logic       lt);
        logic r;
        r = 1'b0;
        case (op)
            OP_EQ:           r = eq;
            OP_NE:           r = !eq;
            OP_LTU, OP_LTS:  r = lt;
            OP_GEU, OP_GES:  r = !lt;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/compare_unit_if.sv
// Handshake bundle between an operand producer/result consumer and compare_unit.
// master drives operands, op, flush and out_ready; slave returns ready, valid and result.
interface cmp_if #(
    parameter int BUS_SIZE    = 16,
    parameter int RESULT_SIZE = 1
);
    logic                   in_valid;
    logic                   in_ready;
    logic [BUS_SIZE-1:0]    a;
    logic [BUS_SIZE-1:0]    b;
    logic [2:0]             op;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [RESULT_SIZE-1:0] res;
    logic                   flag_eq;
    logic                   flag_lt;
    logic                   err;

    modport master (
        output in_valid, a, b, op, flush, out_ready,
        input  in_ready, out_valid, res, flag_eq, flag_lt, err
    );

    modport slave (
        input  in_valid, a, b, op, flush, out_ready,
        output in_ready, out_valid, res, flag_eq, flag_lt, err
    );

endinterface

// File: rtl/compare_chunk.sv
// Combinational unsigned compare of one operand chunk.
// Ports: a, b (chunks in); eq = a==b, lt = a<b (out).
module compare_chunk #(
    parameter int CHUNK_SIZE = 4
) (
    input  logic [CHUNK_SIZE-1:0] a,
    input  logic [CHUNK_SIZE-1:0] b,
    output logic                  eq,
    output logic                  lt
);

    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/compare_unit.sv
// Multi-cycle magnitude/equality comparator, MSB chunk first with early exit.
// Ports: clk, rst_n (async, active low); bus (cmp_if.slave) carries handshakes, operands and results.
module compare_unit
    import cmp_pkg::*;
#(
    parameter int BUS_SIZE    = 16,
    parameter int CHUNK_SIZE  = 4,
    parameter int RESULT_SIZE = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    cmp_if.slave  bus
);

    localparam int NCHUNK = nchunk(BUS_SIZE, CHUNK_SIZE);
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [BUS_SIZE-1:0] MSB_MASK =
        {1'b1, {(BUS_SIZE-1){1'b0}}};

    state_e                 state;
    logic [IW-1:0]          idx;
    logic [BUS_SIZE-1:0]    a_q;
    logic [BUS_SIZE-1:0]    b_q;
    logic [2:0]             op_q;
    logic                   out_valid_q;
    logic [RESULT_SIZE-1:0] res_q;
    logic                   eq_q;
    logic                   lt_q;
    logic                   err_q;

    logic [CHUNK_SIZE-1:0]  a_chunks [NCHUNK];
    logic [CHUNK_SIZE-1:0]  b_chunks [NCHUNK];
    logic                   ch_eq;
    logic                   ch_lt;
    logic                   fin_lt;

    for (genvar i = 0; i < NCHUNK; i++) begin : g_slice
        assign a_chunks[i] = a_q[i*CHUNK_SIZE +: CHUNK_SIZE];
        assign b_chunks[i] = b_q[i*CHUNK_SIZE +: CHUNK_SIZE];
    end

    compare_chunk #(
        .CHUNK_SIZE (CHUNK_SIZE)
    ) u_chunk (
        .a  (a_chunks[idx]),
        .b  (b_chunks[idx]),
        .eq (ch_eq),
        .lt (ch_lt)
    );

    // lt as it will be latched when the scan finishes this cycle.
    assign fin_lt = ch_eq ? 1'b0 : ch_lt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            err_q       <= 1'b0;
        end else if (bus.flush) begin
            state       <= IDLE;
            idx         <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Flipping both sign bits turns a signed order
                        // into an unsigned one for the chunk scan.
                        if (op_signed(bus.op)) begin
                            a_q <= bus.a ^ MSB_MASK;
                            b_q <= bus.b ^ MSB_MASK;
                        end else begin
                            a_q <= bus.a;
                            b_q <= bus.b;
                        end
                        op_q  <= bus.op;
                        idx   <= IW'(NCHUNK - 1);
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!ch_eq || idx == '0) begin
                        eq_q        <= ch_eq;
                        lt_q        <= fin_lt;
                        err_q       <= op_illegal(op_q);
                        res_q       <= RESULT_SIZE'(
                            op_result(op_q, ch_eq, fin_lt));
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        res_q       <= '0;
                        eq_q        <= 1'b0;
                        lt_q        <= 1'b0;
                        err_q       <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;
    assign bus.flag_eq   = eq_q;
    assign bus.flag_lt   = lt_q;
    assign bus.err       = err_q;

endmodule
